// File: rtl/conv_loop_ctrl.sv
// Self-sequencing convolution loop controller: walks m/r/c/n/i/j, one tap per cycle, and
// drives MAC and output-buffer control through a stall-aware delay line. Optional CONV_PERF_CNT_EN adds cycle_count.
module conv_loop_ctrl #(
  parameter int IN_SIZE = 32,
  parameter int IN_CH   = 1,
  parameter int OUT_CH  = 6,
  parameter int K       = 5,
  parameter int ADDR_W  = 16,
  parameter int RD_LAT  = 2,
  parameter int ACC_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              addr_valid,
  output logic              acc_clear,
  output logic              acc_en,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  localparam int OUT_SIZE = IN_SIZE - K + 1;
  localparam int TAPS     = IN_CH * K * K;
  localparam int DLY      = RD_LAT + ACC_LAT;

  localparam longint ADDR_LIM = longint'(1) << ADDR_W;
  localparam longint IFM_MAX  = longint'(IN_CH) * IN_SIZE * IN_SIZE - 1;
  localparam longint WGT_MAX  = longint'(OUT_CH) * TAPS - 1;
  localparam longint OUT_MAX  = longint'(OUT_CH) * OUT_SIZE * OUT_SIZE - 1;

  if (IFM_MAX >= ADDR_LIM || WGT_MAX >= ADDR_LIM || OUT_MAX >= ADDR_LIM) begin : g_addr_chk
    $error("conv_loop_ctrl: ADDR_W too narrow for the address range");
  end
  if (RD_LAT < 1 || ACC_LAT < 1) begin : g_lat_chk
    $error("conv_loop_ctrl: RD_LAT and ACC_LAT must be at least 1");
  end

  localparam logic [31:0] K_M1   = 32'(K - 1);
  localparam logic [31:0] IC_M1  = 32'(IN_CH - 1);
  localparam logic [31:0] OC_M1  = 32'(OUT_CH - 1);
  localparam logic [31:0] OS_M1  = 32'(OUT_SIZE - 1);
  localparam logic [31:0] IN_U   = 32'(IN_SIZE);
  localparam logic [31:0] IN_SQ  = 32'(IN_SIZE * IN_SIZE);
  localparam logic [31:0] OS_U   = 32'(OUT_SIZE);
  localparam logic [31:0] OS_SQ  = 32'(OUT_SIZE * OUT_SIZE);
  localparam logic [31:0] TAPS_U = 32'(TAPS);
  localparam logic [31:0] KK_U   = 32'(K * K);
  localparam logic [31:0] K_U    = 32'(K);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [31:0] inc_wrap(input logic [31:0] v, input logic [31:0] last);
    return (v == last) ? 32'd0 : v + 32'd1;
  endfunction

  state_t            state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [31:0]       m_q, m_d, r_q, r_d, c_q, c_d, n_q, n_d, i_q, i_d, j_q, j_d;
  logic [ADDR_W-1:0] ifm_q, ifm_d, wgt_q, wgt_d;

  // delay line: stage k holds the tap event issued k unstalled cycles ago
  logic [DLY:1]      vld_q, vld_d, pix_q, pix_d, fin_q, fin_d;
  logic [RD_LAT:1]   clr_q, clr_d;
  logic [ADDR_W-1:0] oad_q [1:DLY];
  logic [ADDR_W-1:0] oad_d [1:DLY];

  logic [DLY:0]      s_vld, s_pix, s_fin;
  logic [RD_LAT:0]   s_clr;
  logic [ADDR_W-1:0] s_oad [0:DLY];

  logic tap_v, final_we;
  logic cy_j, cy_i, cy_n, cy_c, cy_r;

  assign tap_v = (state_q == S_RUN);
  assign cy_j  = (j_q == K_M1);
  assign cy_i  = cy_j && (i_q == K_M1);
  assign cy_n  = cy_i && (n_q == IC_M1);
  assign cy_c  = cy_n && (c_q == OS_M1);
  assign cy_r  = cy_c && (r_q == OS_M1);

  always_comb begin
    s_vld    = {vld_q, tap_v};
    s_pix    = {pix_q, cy_n};
    s_fin    = {fin_q, cy_r && (m_q == OC_M1)};
    s_clr    = {clr_q, (n_q == 32'd0) && (i_q == 32'd0) && (j_q == 32'd0)};
    s_oad[0] = ADDR_W'(m_q * OS_SQ + r_q * OS_U + c_q);
    for (int k = 1; k <= DLY; k++) s_oad[k] = oad_q[k];
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign ifm_addr    = ifm_q;
  assign weight_addr = wgt_q;
  assign addr_valid  = tap_v & ~stall;
  assign acc_en      = s_vld[RD_LAT] & ~stall;
  assign acc_clear   = s_vld[RD_LAT] & s_clr[RD_LAT] & ~stall;
  assign out_we      = s_vld[DLY] & s_pix[DLY] & ~stall;
  assign out_addr    = s_oad[DLY];
  assign final_we    = out_we & s_fin[DLY];

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    m_d = m_q; r_d = r_q; c_d = c_q; n_d = n_q; i_d = i_q; j_d = j_q;
    ifm_d   = ifm_q;
    wgt_d   = wgt_q;
    vld_d   = vld_q;
    pix_d   = pix_q;
    fin_d   = fin_q;
    clr_d   = clr_q;
    oad_d   = oad_q;

    if (!stall) begin
      for (int k = 1; k <= DLY; k++) begin
        vld_d[k] = s_vld[k-1];
        pix_d[k] = s_pix[k-1];
        fin_d[k] = s_fin[k-1];
        oad_d[k] = s_oad[k-1];
      end
      for (int k = 1; k <= RD_LAT; k++) clr_d[k] = s_clr[k-1];
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          busy_d  = 1'b1;
          m_d = '0; r_d = '0; c_d = '0; n_d = '0; i_d = '0; j_d = '0;
          ifm_d   = '0;
          wgt_d   = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          j_d = inc_wrap(j_q, K_M1);
          i_d = cy_j ? inc_wrap(i_q, K_M1)  : i_q;
          n_d = cy_i ? inc_wrap(n_q, IC_M1) : n_q;
          c_d = cy_n ? inc_wrap(c_q, OS_M1) : c_q;
          r_d = cy_c ? inc_wrap(r_q, OS_M1) : r_q;
          m_d = cy_r ? inc_wrap(m_q, OC_M1) : m_q;
          ifm_d = ADDR_W'(n_d * IN_SQ + (r_d + i_d) * IN_U + c_d + j_d);
          wgt_d = ADDR_W'(m_d * TAPS_U + n_d * KK_U + i_d * K_U + j_d);
          if (s_fin[0]) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (final_we) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      m_q <= '0; r_q <= '0; c_q <= '0; n_q <= '0; i_q <= '0; j_q <= '0;
      ifm_q   <= '0;
      wgt_q   <= '0;
      vld_q   <= '0;
      pix_q   <= '0;
      fin_q   <= '0;
      clr_q   <= '0;
      for (int k = 1; k <= DLY; k++) oad_q[k] <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      m_q <= m_d; r_q <= r_d; c_q <= c_d; n_q <= n_d; i_q <= i_d; j_q <= j_d;
      ifm_q   <= ifm_d;
      wgt_q   <= wgt_d;
      vld_q   <= vld_d;
      pix_q   <= pix_d;
      fin_q   <= fin_d;
      clr_q   <= clr_d;
      for (int k = 1; k <= DLY; k++) oad_q[k] <= oad_d[k];
    end
  end

`ifdef CONV_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // counts through the DONE cycle so the total covers start-to-done inclusive
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      if (start) cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cycle_count = cnt_q;
`endif

endmodule

// File: tb/tb_conv_loop_ctrl.sv
// Scoreboard bench for conv_loop_ctrl: expected tap, accumulate and write streams are queued
// at start and popped as the DUT emits them; pass timing, stall gating and reset abort are checked.
module tb_conv_loop_ctrl;
  localparam int IN_SIZE = 6, IN_CH = 2, OUT_CH = 2, K = 3, ADDR_W = 16, RD_LAT = 2, ACC_LAT = 1;
  localparam int OS = IN_SIZE - K + 1;
  localparam int TAPS = IN_CH * K * K;
  localparam int NTAPS = OUT_CH * OS * OS * TAPS;
  localparam int NPIX = OUT_CH * OS * OS;

  logic              clock, reset, start, stall;
  logic              busy, done, addr_valid, acc_clear, acc_en, out_we;
  logic [ADDR_W-1:0] ifm_addr, weight_addr, out_addr;
`ifdef CONV_PERF_CNT_EN
  logic [31:0]       cycle_count;
`endif

  conv_loop_ctrl #(
    .IN_SIZE(IN_SIZE), .IN_CH(IN_CH), .OUT_CH(OUT_CH), .K(K),
    .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .ACC_LAT(ACC_LAT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .busy(busy), .done(done), .ifm_addr(ifm_addr), .weight_addr(weight_addr),
    .addr_valid(addr_valid), .acc_clear(acc_clear), .acc_en(acc_en),
    .out_we(out_we), .out_addr(out_addr)
`ifdef CONV_PERF_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int cyc = 0;
  int av_cnt = 0, we_cnt = 0, done_cnt = 0;
  int last_av = 0, last_we = 0, done_cyc = 0;
  logic [31:0] tap_q[$];
  bit          clr_q[$];
  logic [15:0] wa_q[$];
  bit          hold_chk = 1'b0;
  logic [31:0] hold_exp = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_ifm(input int n, input int r, input int c, input int i, input int j);
    return 16'((n * IN_SIZE + r + i) * IN_SIZE + c + j);
  endfunction

  function automatic logic [15:0] exp_wgt(input int m, input int n, input int i, input int j);
    return 16'(((m * IN_CH + n) * K + i) * K + j);
  endfunction

  function automatic logic [31:0] tap_at(input int idx);
    int j, i, n, c, r, m;
    j = idx % K;
    i = (idx / K) % K;
    n = (idx / (K * K)) % IN_CH;
    c = (idx / TAPS) % OS;
    r = (idx / (TAPS * OS)) % OS;
    m = idx / (TAPS * OS * OS);
    return {exp_ifm(n, r, c, i, j), exp_wgt(m, n, i, j)};
  endfunction

  task automatic push_pass();
    for (int m = 0; m < OUT_CH; m++)
      for (int r = 0; r < OS; r++)
        for (int c = 0; c < OS; c++) begin
          for (int n = 0; n < IN_CH; n++)
            for (int i = 0; i < K; i++)
              for (int j = 0; j < K; j++) begin
                tap_q.push_back({exp_ifm(n, r, c, i, j), exp_wgt(m, n, i, j)});
                clr_q.push_back(n == 0 && i == 0 && j == 0);
              end
          wa_q.push_back(16'((m * OS + r) * OS + c));
        end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // observe DUT outputs mid-cycle and retire scoreboard entries
  task automatic sample();
    logic [31:0] e;
    bit          ec;
    logic [15:0] ea;
    @(negedge clock);
    if (!reset) begin
      if (stall) begin
        check("stall_addr_valid", addr_valid, 0);
        check("stall_acc_en", acc_en, 0);
        check("stall_out_we", out_we, 0);
      end
      if (hold_chk) begin
        check("hold_ifm", ifm_addr, hold_exp[31:16]);
        check("hold_weight", weight_addr, hold_exp[15:0]);
      end
      if (addr_valid) begin
        av_cnt++;
        last_av = cyc;
        if (tap_q.size() == 0) check("tap_unexpected", addr_valid, 0);
        else begin
          e = tap_q.pop_front();
          check("ifm_addr", ifm_addr, e[31:16]);
          check("weight_addr", weight_addr, e[15:0]);
        end
      end
      if (acc_en) begin
        if (clr_q.size() == 0) check("acc_unexpected", acc_en, 0);
        else begin
          ec = clr_q.pop_front();
          check("acc_clear", acc_clear, ec);
        end
      end
      if (out_we) begin
        we_cnt++;
        last_we = cyc;
        if (wa_q.size() == 0) check("we_unexpected", out_we, 0);
        else begin
          ea = wa_q.pop_front();
          check("out_addr", out_addr, ea);
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
    end
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic run_pass(input int stall_off, input int stall_len, input bit extra, input bit idle_stall);
    int s, b_av, b_we, b_done;
    b_av = av_cnt; b_we = we_cnt; b_done = done_cnt;
    push_pass();
    s = cyc;
    start = 1'b1;
    stall = idle_stall;
    sample();
    check("start_cycle_av", addr_valid, 0);
    tick();
    start = 1'b0;
    stall = 1'b0;
    while (done_cnt == b_done && cyc < s + 700) begin
      stall = (stall_len > 0) && (cyc >= s + stall_off) && (cyc < s + stall_off + stall_len);
      start = extra && (cyc == s + 50 || cyc == s + 578 || cyc == s + 580);
      hold_chk = stall;
      hold_exp = stall ? tap_at(stall_off - 1) : '0;
      sample();
      if (cyc == s + 1) begin
        check("first_av", addr_valid, 1);
        check("first_busy", busy, 1);
      end
      tick();
    end
    hold_chk = 1'b0;
    stall = 1'b0;
    start = 1'b0;
    check("done_seen", done_cnt - b_done, 1);
    check("done_cycle", done_cyc - s, NTAPS + 4 + stall_len);
    check("last_we_cycle", last_we - s, NTAPS + 3 + stall_len);
    check("last_av_cycle", last_av - s, NTAPS + stall_len);
    check("tap_count", av_cnt - b_av, NTAPS);
    check("we_count", we_cnt - b_we, NPIX);
    check("sb_leftover", tap_q.size() + clr_q.size() + wa_q.size(), 0);
    sample();
`ifdef CONV_PERF_CNT_EN
    check("cycle_count", cycle_count, NTAPS + 4 + stall_len);
`endif
    tick();
    repeat (4) step();
    check("idle_busy", busy, 0);
    check("idle_done_count", done_cnt - b_done, 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    tick();
    tick();
    sample();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr_valid", addr_valid, 0);
    check("rst_acc_en", acc_en, 0);
    check("rst_acc_clear", acc_clear, 0);
    check("rst_out_we", out_we, 0);
    check("rst_ifm", ifm_addr, 0);
    check("rst_weight", weight_addr, 0);
    check("rst_out_addr", out_addr, 0);
    reset = 1'b0;
    tick();

    run_pass(0, 0, 1'b0, 1'b1);
    run_pass(100, 5, 1'b0, 1'b0);

    push_pass();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (100) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_addr_valid", addr_valid, 0);
    check("abort_out_we", out_we, 0);
    tap_q.delete();
    clr_q.delete();
    wa_q.delete();
    tick();
    run_pass(0, 0, 1'b0, 1'b0);

    run_pass(0, 0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
